// File: rtl/led_pwm_pkg.sv
// Shared types and helpers for the LED PWM pattern sequencer.
package led_pwm_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_STATIC  = 2'b01,
    MODE_BREATHE = 2'b10,
    MODE_CHASE   = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam int DUTY_W_DEF = 8;

  // Quarter-scale brightness steps: (sel+1)*2^(duty_w-2)-1
  function automatic logic [15:0] level_from_sw(input logic [1:0] sel, input int duty_w);
    logic [31:0] lvl;
    lvl = ((32'(sel) + 32'd1) << (duty_w - 2)) - 32'd1;
    return lvl[15:0];
  endfunction

endpackage

// File: rtl/led_pwm_sequencer_sw_debounce.sv
// Two-flop synchronizer plus stability counter for a bundle of slide switches.
module sw_debounce #(
  parameter int W            = 4,
  parameter int DEBOUNCE_CYC = 50000
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_sw,
  output logic [W-1:0] o_sw
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

  logic [W-1:0]     meta_q, sync_q;
  logic [W-1:0]     cand_q, cand_d;
  logic [W-1:0]     deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q holds how many consecutive cycles sync_q has matched cand_q
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    deb_d  = deb_q;
    if (sync_q == deb_q) begin
      cand_d = deb_q;
      cnt_d  = '0;
    end else if (sync_q != cand_q) begin
      cand_d = sync_q;
      cnt_d  = CNT_W'(1);
    end else if (cnt_q >= CNT_W'(DEBOUNCE_CYC - 1)) begin
      deb_d = sync_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
      cand_q <= '0;
      deb_q  <= '0;
      cnt_q  <= '0;
    end else begin
      meta_q <= i_sw;
      sync_q <= meta_q;
      cand_q <= cand_d;
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_sw = deb_q;

endmodule

// File: rtl/led_pwm_sequencer.sv
// LED pattern sequencer: switch-selected mode, duties loaded at PWM period ends.
// Optional perceptual correction enabled by defining LED_SEQ_GAMMA_EN.
module led_pwm_sequencer
  import led_pwm_pkg::*;
#(
  parameter int N_LED        = 8,
  parameter int DUTY_W       = DUTY_W_DEF,
  parameter int DEBOUNCE_CYC = 50000,
  parameter int STEP_PERIODS = 4
) (
  input  logic                    i_board_clk,
  input  logic                    i_rst_n,
  input  logic [3:0]              i_sw,
  input  logic                    i_period_done,
  output logic [N_LED*DUTY_W-1:0] o_duty,
  output logic                    o_load
);

  localparam logic [DUTY_W-1:0] MAX = '1;
  localparam int IDX_W = (N_LED > 1) ? $clog2(N_LED) : 1;
  localparam int CNT_W = $clog2(STEP_PERIODS * 8) + 1;

  logic [3:0]              sw_deb;
  mode_e                   mode_q, mode_d, mode_sw;
  dir_e                    dir_q, dir_d;
  logic [DUTY_W-1:0]       level_q, level_d, static_lvl;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d, step_thr;
  logic [N_LED*DUTY_W-1:0] duty_q, duty_d;
  logic                    load_q, load_d;
  logic                    step;

  sw_debounce #(.W(4), .DEBOUNCE_CYC(DEBOUNCE_CYC)) u_sw_debounce (
    .i_clk   (i_board_clk),
    .i_rst_n (i_rst_n),
    .i_sw    (i_sw),
    .o_sw    (sw_deb)
  );

  function automatic logic [DUTY_W-1:0] shape(input logic [DUTY_W-1:0] v);
`ifdef LED_SEQ_GAMMA_EN
    logic [2*DUTY_W-1:0] sq;
    sq = (2*DUTY_W)'(v) * (2*DUTY_W)'(v);
    return sq[2*DUTY_W-1:DUTY_W];
`else
    return v;
`endif
  endfunction

  assign mode_sw    = mode_e'(sw_deb[1:0]);
  assign static_lvl = DUTY_W'(level_from_sw(sw_deb[3:2], DUTY_W));
  assign step_thr   = CNT_W'((STEP_PERIODS << sw_deb[3:2]) - 1);

  // All state advances only on a period boundary; a mode change pre-empts a step
  always_comb begin
    mode_d  = mode_q;
    dir_d   = dir_q;
    level_d = level_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    duty_d  = duty_q;
    load_d  = i_period_done;
    step    = 1'b0;
    if (i_period_done) begin
      if (mode_sw != mode_q) begin
        mode_d  = mode_sw;
        dir_d   = DIR_UP;
        level_d = '0;
        idx_d   = '0;
        cnt_d   = '0;
      end else if (mode_q == MODE_OFF || mode_q == MODE_STATIC) begin
        cnt_d = '0;
      end else if (cnt_q >= step_thr) begin
        cnt_d = '0;
        step  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end

      if (step) begin
        if (mode_q == MODE_BREATHE) begin
          if (dir_q == DIR_UP) begin
            if (level_q == MAX) begin
              dir_d   = DIR_DOWN;
              level_d = MAX - DUTY_W'(1);
            end else begin
              level_d = level_q + DUTY_W'(1);
            end
          end else begin
            if (level_q == '0) begin
              dir_d   = DIR_UP;
              level_d = DUTY_W'(1);
            end else begin
              level_d = level_q - DUTY_W'(1);
            end
          end
        end else begin
          idx_d = (idx_q == IDX_W'(N_LED - 1)) ? '0 : idx_q + IDX_W'(1);
        end
      end

      for (int i = 0; i < N_LED; i++) begin
        case (mode_d)
          MODE_OFF:     duty_d[i*DUTY_W +: DUTY_W] = '0;
          MODE_STATIC:  duty_d[i*DUTY_W +: DUTY_W] = shape(static_lvl);
          MODE_BREATHE: duty_d[i*DUTY_W +: DUTY_W] = shape(level_d);
          default:      duty_d[i*DUTY_W +: DUTY_W] = (idx_d == IDX_W'(i)) ? shape(MAX) : '0;
        endcase
      end
    end
  end

  always_ff @(posedge i_board_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mode_q  <= MODE_OFF;
      dir_q   <= DIR_UP;
      level_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      duty_q  <= '0;
      load_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      level_q <= level_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      load_q  <= load_d;
    end
  end

  assign o_duty = duty_q;
  assign o_load = load_q;

endmodule

// File: tb/tb_led_pwm_sequencer.sv
// Directed bench for led_pwm_sequencer; 16-cycle PWM periods, short debounce.
module tb_led_pwm_sequencer;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        pd    = 1'b0;
  logic [3:0]  sw    = 4'b0000;
  logic [63:0] duty;
  logic        load;

  int n_tests = 0;
  int n_fail  = 0;
  int k       = 0;

  always #5 clk = ~clk;

  led_pwm_sequencer #(
    .N_LED        (8),
    .DUTY_W       (8),
    .DEBOUNCE_CYC (4),
    .STEP_PERIODS (4)
  ) dut (
    .i_board_clk   (clk),
    .i_rst_n       (rst_n),
    .i_sw          (sw),
    .i_period_done (pd),
    .o_duty        (duty),
    .o_load        (load)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] g(input logic [7:0] v);
`ifdef LED_SEQ_GAMMA_EN
    logic [15:0] sq;
    sq = 16'(v) * 16'(v);
    return sq[15:8];
`else
    return v;
`endif
  endfunction

  function automatic logic [63:0] all_led(input logic [7:0] v);
    return {8{v}};
  endfunction

  function automatic logic [63:0] one_led(input int idx, input logic [7:0] v);
    logic [63:0] r;
    r = '0;
    r[idx*8 +: 8] = v;
    return r;
  endfunction

  // 15 idle cycles then a one-cycle period_done; returns 1 after the load edge
  task automatic period();
    repeat (15) @(posedge clk);
    #1 pd = 1'b1;
    @(posedge clk);
    #1 pd = 1'b0;
    check("load_strobe", {63'd0, load}, 64'd1);
    k = k + 1;
  endtask

  task automatic run_to(input int target);
    while (k < target) period();
  endtask

  initial begin
    logic [7:0] static_exp;
`ifdef LED_SEQ_GAMMA_EN
    static_exp = 8'd142;
`else
    static_exp = 8'd191;
`endif

    // Reset and OFF
    repeat (10) @(posedge clk);
    #1;
    check("rst_duty", duty, 64'd0);
    check("rst_load", {63'd0, load}, 64'd0);
    rst_n = 1'b1;
    period();
    check("off_duty", duty, 64'd0);
    @(posedge clk);
    #1 check("load_one_cycle", {63'd0, load}, 64'd0);
    period();
    check("off_duty2", duty, 64'd0);

    // STATIC level 2
    sw = 4'b1001;
    period();
    check("static_duty", duty, all_led(static_exp));
    repeat (5) @(posedge clk);
    #1;
    check("static_stable", duty, all_led(static_exp));
    check("static_no_load", {63'd0, load}, 64'd0);

    // BREATHE ramp
    sw = 4'b0010;
    period();
    k = 0;
    check("br_k0", duty, all_led(g(8'd0)));
    run_to(3);  check("br_k3", duty, all_led(g(8'd0)));
    run_to(4);  check("br_k4", duty, all_led(g(8'd1)));
    run_to(10); check("br_k10", duty, all_led(g(8'd2)));
    @(posedge clk);
    #1 sw = 4'b0011;
    @(posedge clk);
    @(posedge clk);
    #1 sw = 4'b0010;
    run_to(11);   check("glitch_ignored", duty, all_led(g(8'd2)));
    run_to(12);   check("br_k12", duty, all_led(g(8'd3)));
    run_to(1020); check("br_top", duty, all_led(g(8'd255)));
    run_to(1023); check("br_top_hold", duty, all_led(g(8'd255)));
    run_to(1024); check("br_turn_down", duty, all_led(g(8'd254)));
    run_to(2040); check("br_bottom", duty, all_led(g(8'd0)));
    run_to(2044); check("br_turn_up", duty, all_led(g(8'd1)));
    run_to(2443); check("br_level100", duty, all_led(g(8'd100)));

    // CHASE at slowest speed, applied on a period that would also be a breathe step
    sw = 4'b1111;
    period();
    k = 0;
    check("chase_c0", duty, one_led(0, g(8'hFF)));
    run_to(31);  check("chase_c31", duty, one_led(0, g(8'hFF)));
    run_to(32);  check("chase_c32", duty, one_led(1, g(8'hFF)));
    run_to(224); check("chase_c224", duty, one_led(7, g(8'hFF)));
    run_to(255); check("chase_c255", duty, one_led(7, g(8'hFF)));
    run_to(256); check("chase_wrap", duty, one_led(0, g(8'hFF)));

    // Asynchronous reset during a breathe ramp
    sw = 4'b0010;
    period();
    k = 0;
    check("br2_k0", duty, all_led(g(8'd0)));
    run_to(12);
    check("br2_k12", duty, all_led(g(8'd3)));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_duty", duty, 64'd0);
    check("async_rst_load", {63'd0, load}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    period();
    check("post_rst_duty", duty, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
